rv32i_single_cycle_core: RTL and testbench

- Single-cycle RV32I integer core; each CLK rising edge retires one instruction.
- Instruction memory is external: combinational read addressed by the current PC.
- Data memory is external: combinational read, synchronous write, with size select.
- IsError flags an illegal or halting instruction; the system bench runs until IsError rises.

---
 rtl/rv32i_single_cycle_core_pkg.sv | 56 +++++
 rtl/rv32i_regfile.sv | 30 +++
 rtl/rv32i_single_cycle_core.sv | 108 ++++++++++
 tb/tb_rv32i_single_cycle_core.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_single_cycle_core_pkg.sv
// rv32i_single_cycle_core_pkg: opcodes, load/store size codes and ALU helpers shared by the core
package rv32i_single_cycle_core_pkg;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_FENCE  = 7'h0F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] alu_eval(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'b0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
            ALU_OR:   return a | b;
            default:  return a & b;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// rv32i_regfile: two combinational read ports, one edge-triggered write port, x0 hardwired to zero
module rv32i_regfile #(
    parameter int REG_COUNT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    logic [31:0] regs [1:REG_COUNT-1];

    assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];

    // clear everything on reset, otherwise commit the retiring write; x0 writes are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (wr_en && wr_addr != 5'd0) begin
            regs[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/rv32i_single_cycle_core.sv
// rv32i_single_cycle_core: single-cycle RV32I core retiring one instruction per rising clock edge
module rv32i_single_cycle_core import rv32i_single_cycle_core_pkg::*; #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          REG_COUNT = 32
) (
    input  logic        CLK,
    input  logic        reset,
    output logic [31:0] pcLastState,
    input  logic [31:0] currentInstrucntion,
    input  logic [31:0] dataMemoryOutput,
    output logic [31:0] dataMemoryOut,
    output logic [31:0] dataMemoryAdress,
    output logic [2:0]  MemSize,
    output logic        MemWE,
    output logic        IsError
);

    logic [31:0] pc, instr, rs1_val, rs2_val, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] alu_y, rd_val, target, next_pc;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic        err_q, legal_op, cmp, taken, redirect, illegal, writes_rd, is_load, is_store;
    alu_op_e     alu_op;

    assign instr  = currentInstrucntion;
    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    rv32i_regfile #(.REG_COUNT(REG_COUNT)) u_rf (
        .clk      (CLK),
        .rst_n    (reset),
        .rs1_addr (instr[19:15]),
        .rs2_addr (instr[24:20]),
        .rs1_data (rs1_val),
        .rs2_data (rs2_val),
        .wr_en    (writes_rd && !IsError),
        .wr_addr  (instr[11:7]),
        .wr_data  (rd_val)
    );

    // opcode/funct legality and ALU operation selection
    always_comb begin
        legal_op = 1'b0;
        alu_op   = ALU_ADD;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: legal_op = 1'b1;
            OP_JALR:   legal_op = f3 == 3'b000;
            OP_BRANCH: legal_op = f3[2:1] != 2'b01;
            OP_LOAD:   legal_op = f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
            OP_STORE:  legal_op = f3 inside {F3_B, F3_H, F3_W};
            OP_FENCE:  legal_op = f3 == 3'b000;
            OP_SYSTEM: legal_op = 1'b0;
            OP_IMM: begin
                legal_op = f3 == 3'b001 ? f7 == 7'h00 : f3 == 3'b101 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
                alu_op   = alu_sel(f3, f3 == 3'b101 && f7[5]);
            end
            OP_REG: begin
                legal_op = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
                alu_op   = alu_sel(f3, f7[5]);
            end
            default: legal_op = 1'b0;
        endcase
    end

    assign alu_y = alu_eval(alu_op, rs1_val, opcode == OP_REG ? rs2_val : imm_i);

    assign cmp      = f3[2:1] == 2'b00 ? rs1_val == rs2_val : f3[1] ? rs1_val < rs2_val : $signed(rs1_val) < $signed(rs2_val);
    assign taken    = opcode == OP_BRANCH && (cmp ^ f3[0]);
    assign redirect = taken || opcode == OP_JAL || opcode == OP_JALR;
    assign target   = opcode == OP_JAL ? pc + imm_j : opcode == OP_JALR ? (rs1_val + imm_i) & ~32'h1 : pc + imm_b;
    assign next_pc  = redirect ? target : pc + 32'd4;

    assign illegal = !legal_op || instr == '0 || instr == '1 || (redirect && target[1]);
    assign IsError = err_q || illegal;

    assign is_load   = opcode == OP_LOAD;
    assign is_store  = opcode == OP_STORE;
    assign writes_rd = opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG};
    assign rd_val    = opcode == OP_LUI ? imm_u :
                       opcode == OP_AUIPC ? pc + imm_u :
                       (opcode == OP_JAL || opcode == OP_JALR) ? pc + 32'd4 :
                       is_load ? dataMemoryOutput : alu_y;

    assign dataMemoryAdress = (is_load || is_store) ? rs1_val + (is_store ? imm_s : imm_i) : '0;
    assign MemSize          = (is_load || is_store) ? f3 : F3_W;
    assign dataMemoryOut    = rs2_val;
    assign MemWE            = is_store && !IsError && reset;
    assign pcLastState      = pc;

    // PC advances only while no error is present; the error flag latches until reset
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            pc    <= RESET_PC;
            err_q <= 1'b0;
        end else begin
            err_q <= IsError;
            if (!IsError) pc <= next_pc;
        end
    end

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// tb_rv32i_single_cycle_core: directed vector table, corner sequences and random ISS comparison
module tb_rv32i_single_cycle_core;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = NOP;
    logic [31:0] pc, dm_rdata, dm_wdata, dm_addr;
    logic [2:0]  dm_size;
    logic        dm_we, is_error;
    logic [7:0]  dm [256];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv32i_single_cycle_core dut (
        .CLK                 (clk),
        .reset               (rst_n),
        .pcLastState         (pc),
        .currentInstrucntion (instr),
        .dataMemoryOutput    (dm_rdata),
        .dataMemoryOut       (dm_wdata),
        .dataMemoryAdress    (dm_addr),
        .MemSize             (dm_size),
        .MemWE               (dm_we),
        .IsError             (is_error)
    );

    function automatic int nbytes(input logic [2:0] sz);
        return sz[1:0] == 2'd0 ? 1 : sz[1:0] == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic [31:0] mem_read(input logic [7:0] m [256], input logic [31:0] a, input logic [2:0] sz);
        logic [31:0] w;
        w = {m[8'(a + 32'd3)], m[8'(a + 32'd2)], m[8'(a + 32'd1)], m[8'(a)]};
        case (sz)
            3'd0:    return 32'($signed(w[7:0]));
            3'd1:    return 32'($signed(w[15:0]));
            3'd4:    return {24'b0, w[7:0]};
            3'd5:    return {16'b0, w[15:0]};
            default: return w;
        endcase
    endfunction

    assign dm_rdata = mem_read(dm, dm_addr, dm_size);

    always @(posedge clk)
        if (dm_we)
            for (int k = 0; k < 4; k++)
                if (k < nbytes(dm_size)) dm[8'(dm_addr + 32'(k))] <= dm_wdata[8*k +: 8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference ISS ----------------
    logic [31:0] m_x [32];
    logic [31:0] m_pc;
    logic        m_err;
    logic [7:0]  m_dm [256];
    logic [31:0] e_pc, e_addr, e_wdata;
    logic [2:0]  e_size;
    logic        e_we, e_err;

    task automatic model_reset();
        m_pc = 32'h0;
        m_err = 1'b0;
        for (int i = 0; i < 32; i++) m_x[i] = 32'h0;
    endtask

    function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            default: return a >= b;
        endcase
    endfunction

    function automatic logic [31:0] alu_model(input logic [2:0] f3, input logic alt, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return alt ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic model_step(input logic [31:0] w);
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] a, b, ii, is, ib, iu, ij, res, npc;
        logic        ok, wr;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25]; rd = w[11:7];
        a = m_x[w[19:15]]; b = m_x[w[24:20]];
        ii = 32'($signed(w[31:20]));
        is = 32'($signed({w[31:25], w[11:7]}));
        ib = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
        iu = {w[31:12], 12'h000};
        ij = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
        ok = 1'b1; wr = 1'b0; res = 32'h0; npc = m_pc + 32'd4;
        e_we = 1'b0; e_addr = 32'h0; e_size = 3'd2; e_wdata = b;
        case (op)
            7'h37: begin wr = 1'b1; res = iu; end
            7'h17: begin wr = 1'b1; res = m_pc + iu; end
            7'h6F: begin wr = 1'b1; res = m_pc + 32'd4; npc = m_pc + ij; end
            7'h67: begin ok = f3 == 3'd0; wr = 1'b1; res = m_pc + 32'd4; npc = (a + ii) & ~32'h1; end
            7'h63: begin ok = f3 != 3'd2 && f3 != 3'd3; if (ok && branch_taken(f3, a, b)) npc = m_pc + ib; end
            7'h03: begin
                ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; wr = 1'b1;
                e_addr = a + ii; e_size = f3; res = mem_read(m_dm, e_addr, f3);
            end
            7'h23: begin ok = f3 <= 3'd2; e_addr = a + is; e_size = f3; e_we = 1'b1; end
            7'h13: begin
                ok = f3 == 3'd1 ? f7 == 7'h00 : f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
                wr = 1'b1; res = alu_model(f3, f3 == 3'd5 && f7 == 7'h20, a, ii);
            end
            7'h33: begin
                ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                wr = 1'b1; res = alu_model(f3, f7 == 7'h20, a, b);
            end
            7'h0F: ok = f3 == 3'd0;
            default: ok = 1'b0;
        endcase
        if (w == 32'h0 || w == 32'hFFFF_FFFF || npc[1]) ok = 1'b0;
        e_err = m_err || !ok;
        if (e_err) e_we = 1'b0;
        e_pc = m_pc;
        if (!e_err) begin
            if (wr && rd != 5'd0) m_x[rd] = res;
            if (e_we)
                for (int k = 0; k < 4; k++)
                    if (k < nbytes(f3)) m_dm[8'(e_addr + 32'(k))] = b[8*k +: 8];
            m_pc = npc;
        end
        m_err = e_err;
    endtask

    task automatic check_outputs();
        check("pc", pc, e_pc);
        check("is_error", 32'(is_error), 32'(e_err));
        check("mem_we", 32'(dm_we), 32'(e_we));
        check("mem_addr", dm_addr, e_addr);
        check("mem_size", 32'(dm_size), 32'(e_size));
        if (e_we) check("mem_wdata", dm_wdata, e_wdata);
    endtask

    function automatic logic [31:0] gen_instr();
        int          r = int'($urandom_range(0, 99));
        logic [4:0]  rd = 5'($urandom_range(0, 7));
        logic [4:0]  rs1 = 5'($urandom_range(0, 7));
        logic [4:0]  rs2 = 5'($urandom_range(0, 7));
        logic [2:0]  f3 = 3'($urandom_range(0, 7));
        logic [31:0] imm = $urandom;
        int          o = int'($urandom_range(0, 32)) - 16;
        logic [31:0] off = 32'(o * 4);
        int          k = int'($urandom_range(0, 4));
        logic [2:0]  lf = k < 3 ? 3'(k) : 3'(k + 1);
        logic [2:0]  bf = (f3 == 3'd2 || f3 == 3'd3) ? f3 ^ 3'b100 : f3;
        if (r < 30) return {f3 == 3'd1 ? 7'h00 : f3 == 3'd5 ? ($urandom_range(0, 1) != 0 ? 7'h20 : 7'h00) : imm[11:5], imm[4:0], rs1, f3, rd, 7'h13};
        if (r < 55) return {((f3 == 3'd0 || f3 == 3'd5) && imm[0]) ? 7'h20 : 7'h00, rs2, rs1, f3, rd, 7'h33};
        if (r < 62) return {imm[31:12], rd, imm[0] ? 7'h37 : 7'h17};
        if (r < 72) return {imm[11:5], rs2, rs1, 3'($urandom_range(0, 2)), imm[4:0], 7'h23};
        if (r < 82) return {imm[11:0], rs1, lf, rd, 7'h03};
        if (r < 91) return {off[12], off[10:5], rs2, rs1, bf, off[4:1], off[11], 7'h63};
        if (r < 94) return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6F};
        if (r < 96) return {imm[11:0], rs1, 3'b000, rd, 7'h67};
        if (r < 98) return $urandom;
        return 32'h0000_000F;
    endfunction

    task automatic apply_reset();
        instr = NOP;
        rst_n = 1'b0;
        #1;
        check("reset_pc", pc, 32'h0);
        check("reset_is_error", 32'(is_error), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        err;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
    } vec_t;

    vec_t tbl [$];
    int   err_run = 0;

    initial begin
        tbl.push_back('{NOP,          32'h00, 1'b0, 1'b0, 32'h00, 32'h0,         3'd2});
        tbl.push_back('{32'h00500093, 32'h04, 1'b0, 1'b0, 32'h00, 32'h0,         3'd2});
        tbl.push_back('{32'hFFD00113, 32'h08, 1'b0, 1'b0, 32'h00, 32'h0,         3'd2});
        tbl.push_back('{32'h002081B3, 32'h0C, 1'b0, 1'b0, 32'h00, 32'h0,         3'd2});
        tbl.push_back('{32'h00112233, 32'h10, 1'b0, 1'b0, 32'h00, 32'h0,         3'd2});
        tbl.push_back('{32'h001132B3, 32'h14, 1'b0, 1'b0, 32'h00, 32'h0,         3'd2});
        tbl.push_back('{32'h00302423, 32'h18, 1'b0, 1'b1, 32'h08, 32'h2,         3'd2});
        tbl.push_back('{32'h00802303, 32'h1C, 1'b0, 1'b0, 32'h08, 32'h0,         3'd2});
        tbl.push_back('{32'h00108463, 32'h20, 1'b0, 1'b0, 32'h00, 32'h0,         3'd2});
        tbl.push_back('{32'h00109463, 32'h28, 1'b0, 1'b0, 32'h00, 32'h0,         3'd2});
        tbl.push_back('{32'h00402623, 32'h2C, 1'b0, 1'b1, 32'h0C, 32'h1,         3'd2});
        tbl.push_back('{32'h00502823, 32'h30, 1'b0, 1'b1, 32'h10, 32'h0,         3'd2});
        tbl.push_back('{32'h00602A23, 32'h34, 1'b0, 1'b1, 32'h14, 32'h2,         3'd2});
        tbl.push_back('{NOP,          32'h38, 1'b0, 1'b0, 32'h00, 32'h0,         3'd2});
        tbl.push_back('{NOP,          32'h3C, 1'b0, 1'b0, 32'h00, 32'h0,         3'd2});
        tbl.push_back('{32'h010000EF, 32'h40, 1'b0, 1'b0, 32'h00, 32'h0,         3'd2});
        tbl.push_back('{32'h00102023, 32'h50, 1'b0, 1'b1, 32'h00, 32'h44,        3'd2});
        tbl.push_back('{32'h00209123, 32'h54, 1'b0, 1'b1, 32'h46, 32'hFFFF_FFFD, 3'd1});
        tbl.push_back('{32'h00000000, 32'h58, 1'b1, 1'b0, 32'h00, 32'h0,         3'd2});
        tbl.push_back('{32'h00102023, 32'h58, 1'b1, 1'b0, 32'h00, 32'h0,         3'd2});
        tbl.push_back('{32'h00302423, 32'h58, 1'b1, 1'b0, 32'h08, 32'h0,         3'd2});
        tbl.push_back('{NOP,          32'h58, 1'b1, 1'b0, 32'h00, 32'h0,         3'd2});

        #2;
        check("reset_pc", pc, 32'h0);
        check("reset_is_error", 32'(is_error), 32'h0);
        instr = 32'h00302423;
        #1;
        check("reset_mem_we_blocked", 32'(dm_we), 32'h0);
        instr = NOP;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            instr = tbl[i].ins;
            @(negedge clk);
            check($sformatf("vec%0d_pc", i), pc, tbl[i].pc);
            check($sformatf("vec%0d_is_error", i), 32'(is_error), 32'(tbl[i].err));
            check($sformatf("vec%0d_mem_we", i), 32'(dm_we), 32'(tbl[i].we));
            check($sformatf("vec%0d_mem_addr", i), dm_addr, tbl[i].addr);
            check($sformatf("vec%0d_mem_size", i), 32'(dm_size), 32'(tbl[i].size));
            if (tbl[i].we) check($sformatf("vec%0d_mem_wdata", i), dm_wdata, tbl[i].wdata);
            @(posedge clk);
            #1;
        end

        apply_reset();
        instr = 32'h0000_0073;
        #1;
        check("ecall_is_error", 32'(is_error), 32'h1);
        @(posedge clk);
        #1;
        instr = NOP;
        #1;
        check("ecall_sticky", 32'(is_error), 32'h1);
        check("ecall_pc_frozen", pc, 32'h0);

        apply_reset();
        instr = 32'h0000_0363;
        #1;
        check("misaligned_branch_err", 32'(is_error), 32'h1);
        apply_reset();
        instr = 32'h0000_1363;
        #1;
        check("untaken_misaligned_ok", 32'(is_error), 32'h0);
        @(posedge clk);
        #1;
        check("untaken_pc", pc, 32'h4);
        instr = 32'hFFFF_FFFF;
        #1;
        check("all_ones_err", 32'(is_error), 32'h1);

        apply_reset();
        instr = 32'h0050_0093;
        @(posedge clk);
        #1;
        instr = NOP;
        @(negedge clk);
        check("pre_reset_pc", pc, 32'h4);
        rst_n = 1'b0;
        #1;
        check("async_reset_pc", pc, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        instr = 32'h0010_2023;
        @(negedge clk);
        check("reset_cleared_x1", dm_wdata, 32'h0);
        check("reset_store_we", 32'(dm_we), 32'h1);
        @(posedge clk);
        #1;

        apply_reset();
        m_dm = dm;
        for (int n = 0; n < 3000; n++) begin
            instr = gen_instr();
            model_step(instr);
            @(negedge clk);
            check_outputs();
            @(posedge clk);
            #1;
            if (m_err) begin
                err_run++;
                if (err_run > 2) begin
                    apply_reset();
                    err_run = 0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
